// File: rtl/uart0_pkg.sv
// uart0_pkg: definitions shared by the uart0 receive path (and the uart0_tx default rate).
//   rx_state_e        - receiver FSM encodings (3 bits)
//   DATA_BITS         - payload bits per frame (8N1)
//   PRESCALER_DEFAULT - bus clocks per bit, 9600 bps at 6 MHz
//   PRE_CNT_W         - width of the bit-period counter
//   majority3()       - 2-of-3 vote used by the oversampling build
package uart0_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StStop  = 3'd3,
        StBreak = 3'd4
    } rx_state_e;

    localparam int unsigned DATA_BITS         = 8;
    localparam int unsigned PRESCALER_DEFAULT = 625;
    localparam int unsigned PRE_CNT_W         = 12;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart0_sync.sv
// uart0_sync: SYNC_STAGES-deep flop chain bringing an asynchronous line into the clk domain.
// Flops reset to 1 so an idle-high line does not look like a start bit coming out of reset.
//   clk   - bus clock
//   rst_n - synchronous active-low reset
//   d     - asynchronous input
//   q     - synchronized output
module uart0_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart0_rx.sv
// uart0_rx: 8N1 UART receiver on the bus clock, LSB first, idle-high line.
// The received byte is held for a bus read together with full/overrun/framing status.
//   clk          - bus clock, all logic on posedge
//   rst_n        - synchronous active-low reset
//   rx_in        - asynchronous serial line
//   rd_en        - one-cycle read strobe; consumes the byte and clears all flags
//   rd_data      - {24'b0, byte}
//   rd_full      - byte available
//   rd_overrun   - a complete byte was dropped because rd_full was already set
//   rd_frame_err - last frame had a low stop bit
// Build option: define UART0_RX_MAJORITY_EN to take each decision as a 2-of-3 vote of rx_s
// at counts T-2, T-1 and T instead of a single sample at T. Ports and timing are unchanged.
module uart0_rx import uart0_pkg::*; #(
    parameter int unsigned PRESCALER   = PRESCALER_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_in,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        rd_full,
    output logic        rd_overrun,
    output logic        rd_frame_err
);

    localparam logic [PRE_CNT_W-1:0] PreMax  = PRE_CNT_W'(PRESCALER - 1);
    localparam logic [PRE_CNT_W-1:0] HalfM1  = PRE_CNT_W'(PRESCALER / 2 - 1);
    localparam int unsigned          BitCntW = $clog2(DATA_BITS);
    localparam logic [BitCntW-1:0]   BitLast = BitCntW'(DATA_BITS - 1);

    rx_state_e              state_q, state_d;
    logic [PRE_CNT_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [BitCntW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   rd_data_q, rd_data_d;
    logic                   rd_full_q, rd_full_d;
    logic                   rd_overrun_q, rd_overrun_d;
    logic                   rd_frame_err_q, rd_frame_err_d;

    logic rx_s;
    logic rx_vote;
    logic pre_hit;
    logic half_hit;
    logic stop_sample;

    uart0_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx_in),
        .q    (rx_s)
    );

`ifdef UART0_RX_MAJORITY_EN
    // The two previous rx_s values; combined with the current one they span T-2..T.
    logic [1:0] hist_q, hist_d;

    always_comb begin
        hist_d  = {hist_q[0], rx_s};
        rx_vote = majority3({hist_q, rx_s});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end
`else
    assign rx_vote = rx_s;
`endif

    assign pre_hit     = (pre_cnt_q == PreMax);
    assign half_hit    = (pre_cnt_q == HalfM1);
    assign stop_sample = (state_q == StStop) && pre_hit;

    // State register (FSM, datapath and read-side status).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            pre_cnt_q      <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            rd_data_q      <= '0;
            rd_full_q      <= 1'b0;
            rd_overrun_q   <= 1'b0;
            rd_frame_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pre_cnt_q      <= pre_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            rd_data_q      <= rd_data_d;
            rd_full_q      <= rd_full_d;
            rd_overrun_q   <= rd_overrun_d;
            rd_frame_err_q <= rd_frame_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d   = StStart;
                    pre_cnt_d = '0;
                end
            end
            StStart: begin
                pre_cnt_d = pre_cnt_q + 1'b1;
                if (half_hit) begin
                    if (!rx_vote) begin
                        state_d   = StData;
                        pre_cnt_d = '0;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = StIdle;  // too short to be a start bit
                    end
                end
            end
            StData: begin
                pre_cnt_d = pre_cnt_q + 1'b1;
                if (pre_hit) begin
                    shift_d   = {rx_vote, shift_q[DATA_BITS-1:1]};
                    pre_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BitLast) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                pre_cnt_d = pre_cnt_q + 1'b1;
                if (pre_hit) begin
                    pre_cnt_d = '0;
                    state_d   = rx_vote ? StIdle : StBreak;
                end
            end
            StBreak: begin
                // Hold off until the line returns high so a stuck-low line cannot retrigger.
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output / status logic. A delivery in the same cycle as rd_en wins over the clear.
    always_comb begin
        rd_data_d      = rd_data_q;
        rd_full_d      = rd_full_q;
        rd_overrun_d   = rd_overrun_q;
        rd_frame_err_d = rd_frame_err_q;
        if (rd_en) begin
            rd_full_d      = 1'b0;
            rd_overrun_d   = 1'b0;
            rd_frame_err_d = 1'b0;
        end
        if (stop_sample) begin
            if (rx_vote) begin
                if (!rd_full_q || rd_en) begin
                    rd_data_d      = shift_q;
                    rd_full_d      = 1'b1;
                    rd_frame_err_d = 1'b0;
                end else begin
                    rd_overrun_d = 1'b1;
                end
            end else begin
                rd_frame_err_d = 1'b1;
            end
        end
    end

    assign rd_data      = {{(32 - DATA_BITS){1'b0}}, rd_data_q};
    assign rd_full      = rd_full_q;
    assign rd_overrun   = rd_overrun_q;
    assign rd_frame_err = rd_frame_err_q;

endmodule
